// File: rtl/mem_responder.sv
// mem_responder: word-addressed 16-bit memory behind a small request/response
// FSM. Serves single-word loads/stores and LM/SM-style mask transactions, one
// word per XFER cycle, with a fixed number of wait states before each word.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | ready for a request; req_ready=1
// ST_WAIT | counting wait states before the current word
// ST_XFER | one-cycle word transfer; rsp_valid=1, store commits at close
// ST_DONE | one-cycle end-of-transaction pulse; done=1
module mem_responder #(
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 1
) (
  input  logic        clk,
  input  logic        proc_rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic        req_multi,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_mask,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [2:0]  rsp_reg,
  output logic [15:0] rsp_data,
  output logic        done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_XFER,
    ST_DONE
  } state_t;

  // Wait counter is a down-counter loaded on word entry; zero means "last wait cycle".
  localparam logic [2:0] WAIT_LOAD = 3'((WAIT_CYC > 0) ? (WAIT_CYC - 1) : 0);
  localparam logic       WAIT_NONE = (WAIT_CYC == 0);

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  mask_q, mask_d;
  logic [2:0]  off_q, off_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  reg_q, reg_d;

  logic [15:0] mem_q [2**ADDR_W];

  logic [7:0]        mask_acc;
  logic [7:0]        mask_rem;
  state_t            word_entry;
  logic [15:0]       addr_sum;
  logic [ADDR_W-1:0] word_addr;
  logic              unused_addr_hi;

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign word_entry     = WAIT_NONE ? ST_XFER : ST_WAIT;
  // Offset advances by one per word regardless of which mask bit was served.
  assign addr_sum       = addr_q + {13'd0, off_q};
  assign word_addr      = addr_sum[ADDR_W-1:0];
  assign unused_addr_hi = ^addr_sum[15:ADDR_W];

  // State and transaction context registers; reset aborts any transaction.
  always_ff @(posedge clk or negedge proc_rst) begin
    if (!proc_rst) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      addr_q  <= 16'd0;
      mask_q  <= 8'd0;
      off_q   <= 3'd0;
      cnt_q   <= 3'd0;
      reg_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      reg_q   <= reg_d;
    end
  end

  // Next-state and context update; rsp_reg is registered on entry to each word.
  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    addr_d   = addr_q;
    mask_d   = mask_q;
    off_d    = off_q;
    cnt_d    = cnt_q;
    reg_d    = reg_q;
    mask_acc = req_multi ? req_mask : 8'h01;
    mask_rem = mask_q & ~(8'h01 << reg_q);
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          mask_d  = mask_acc;
          off_d   = 3'd0;
          cnt_d   = WAIT_LOAD;
          reg_d   = lowest_set(mask_acc);
          state_d = (mask_acc == 8'd0) ? ST_DONE : word_entry;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) state_d = ST_XFER;
        else               cnt_d   = cnt_q - 3'd1;
      end
      ST_XFER: begin
        mask_d  = mask_rem;
        off_d   = off_q + 3'd1;
        cnt_d   = WAIT_LOAD;
        reg_d   = lowest_set(mask_rem);
        state_d = (mask_rem == 8'd0) ? ST_DONE : word_entry;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Store commits at the closing edge of XFER only; memory is never reset.
  always_ff @(posedge clk) begin
    if (state_q == ST_XFER && write_q) mem_q[word_addr] <= req_wdata;
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_XFER);
  assign done      = (state_q == ST_DONE);
  assign rsp_reg   = reg_q;

  // Response data: asynchronous read for loads, echo of store data otherwise.
  always_comb begin
    rsp_data = 16'd0;
    if (rsp_valid) rsp_data = write_q ? req_wdata : mem_q[word_addr];
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (ADDR_W=8, WAIT_CYC=1).
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        proc_rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic        req_multi = 1'b0;
  logic [15:0] req_addr = 16'd0;
  logic [7:0]  req_mask = 8'd0;
  logic [15:0] req_wdata = 16'd0;
  logic        req_ready;
  logic        rsp_valid;
  logic [2:0]  rsp_reg;
  logic [15:0] rsp_data;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [15:0] wdata_tbl [8];
  int          got_n;
  int          done_cyc;
  logic [2:0]  got_reg [8];
  logic [15:0] got_data [8];
  int          got_cyc [8];

  mem_responder #(.ADDR_W(8), .WAIT_CYC(1)) dut (
    .clk(clk), .proc_rst(proc_rst), .req_valid(req_valid), .req_write(req_write),
    .req_multi(req_multi), .req_addr(req_addr), .req_mask(req_mask),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_reg(rsp_reg), .rsp_data(rsp_data), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issues one request and records every response pulse until done (bounded).
  task automatic run_txn(input logic wr, input logic mu, input logic [15:0] ad,
                         input logic [7:0] mk, input bit busy);
    got_n    = 0;
    done_cyc = -1;
    for (int i = 0; i < 8; i++) begin
      got_reg[i] = 'x; got_data[i] = 'x; got_cyc[i] = -1;
    end
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_multi = mu;
    req_addr = ad; req_mask = mk; req_wdata = wdata_tbl[0];
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      req_valid = (busy && c == 1);
      if (rsp_valid && got_n < 8) begin
        req_wdata = wdata_tbl[got_n];
        #1;
        got_reg[got_n]  = rsp_reg;
        got_data[got_n] = rsp_data;
        got_cyc[got_n]  = c;
        got_n++;
      end
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
    checks++; if (rsp_reg !== 3'd0) begin errors++; $display("FAIL rst_rsp_reg: got %0d expected 0", rsp_reg); end
    checks++; if (rsp_data !== 16'd0) begin errors++; $display("FAIL rst_rsp_data: got %h expected 0000", rsp_data); end
    @(negedge clk);
    proc_rst = 1'b1;
  endtask

  task automatic test_single();
    wdata_tbl[0] = 16'hBEEF;
    run_txn(1'b1, 1'b0, 16'h0010, 8'h00, 1'b0);
    checks++; if (got_n !== 1) begin errors++; $display("FAIL st_pulses: got %0d expected 1", got_n); end
    checks++; if (got_cyc[0] !== 2) begin errors++; $display("FAIL st_cycle: got %0d expected 2", got_cyc[0]); end
    checks++; if (got_data[0] !== 16'hBEEF) begin errors++; $display("FAIL st_echo: got %h expected beef", got_data[0]); end
    checks++; if (done_cyc !== 3) begin errors++; $display("FAIL st_done: got %0d expected 3", done_cyc); end
    wdata_tbl[0] = 16'h0000;
    run_txn(1'b0, 1'b0, 16'h0010, 8'hFF, 1'b0);
    checks++; if (got_n !== 1) begin errors++; $display("FAIL ld_pulses: got %0d expected 1", got_n); end
    checks++; if (got_cyc[0] !== 2) begin errors++; $display("FAIL ld_cycle: got %0d expected 2", got_cyc[0]); end
    checks++; if (got_data[0] !== 16'hBEEF) begin errors++; $display("FAIL ld_data: got %h expected beef", got_data[0]); end
    checks++; if (got_reg[0] !== 3'd0) begin errors++; $display("FAIL ld_reg: got %0d expected 0", got_reg[0]); end
    checks++; if (done_cyc !== 3) begin errors++; $display("FAIL ld_done: got %0d expected 3", done_cyc); end
  endtask

  task automatic test_multi_load();
    logic [2:0]  exp_reg [4];
    logic [15:0] exp_dat [4];
    exp_reg = '{3'd0, 3'd2, 3'd5, 3'd7};
    exp_dat = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < 4; i++) wdata_tbl[i] = exp_dat[i];
    run_txn(1'b1, 1'b1, 16'h0020, 8'h0F, 1'b0);
    run_txn(1'b0, 1'b1, 16'h0020, 8'b1010_0101, 1'b0);
    checks++; if (got_n !== 4) begin errors++; $display("FAIL mld_pulses: got %0d expected 4", got_n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_reg[i] !== exp_reg[i]) begin errors++; $display("FAIL mld_reg[%0d]: got %0d expected %0d", i, got_reg[i], exp_reg[i]); end
      checks++; if (got_data[i] !== exp_dat[i]) begin errors++; $display("FAIL mld_data[%0d]: got %h expected %h", i, got_data[i], exp_dat[i]); end
      checks++; if (got_cyc[i] !== 2 * i + 2) begin errors++; $display("FAIL mld_cycle[%0d]: got %0d expected %0d", i, got_cyc[i], 2 * i + 2); end
    end
    checks++; if (done_cyc !== 9) begin errors++; $display("FAIL mld_done: got %0d expected 9", done_cyc); end
  endtask

  task automatic test_multi_store_wrap();
    logic [15:0] exp_dat [4];
    exp_dat = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
    for (int i = 0; i < 4; i++) wdata_tbl[i] = exp_dat[i];
    run_txn(1'b1, 1'b1, 16'h00FE, 8'h0F, 1'b0);
    checks++; if (got_n !== 4) begin errors++; $display("FAIL wst_pulses: got %0d expected 4", got_n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_reg[i] !== 3'(i)) begin errors++; $display("FAIL wst_reg[%0d]: got %0d expected %0d", i, got_reg[i], i); end
      checks++; if (got_data[i] !== exp_dat[i]) begin errors++; $display("FAIL wst_echo[%0d]: got %h expected %h", i, got_data[i], exp_dat[i]); end
    end
    checks++; if (done_cyc !== 9) begin errors++; $display("FAIL wst_done: got %0d expected 9", done_cyc); end
    run_txn(1'b0, 1'b1, 16'h00FE, 8'h0F, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_data[i] !== exp_dat[i]) begin errors++; $display("FAIL wld_data[%0d]: got %h expected %h", i, got_data[i], exp_dat[i]); end
    end
    run_txn(1'b0, 1'b0, 16'h0001, 8'h00, 1'b0);
    checks++; if (got_data[0] !== 16'hA003) begin errors++; $display("FAIL wld_0x01: got %h expected a003", got_data[0]); end
    run_txn(1'b0, 1'b0, 16'h0100, 8'h00, 1'b0);
    checks++; if (got_data[0] !== 16'hA002) begin errors++; $display("FAIL wld_0x100: got %h expected a002", got_data[0]); end
  endtask

  task automatic test_empty_mask();
    run_txn(1'b0, 1'b1, 16'h0030, 8'h00, 1'b0);
    checks++; if (got_n !== 0) begin errors++; $display("FAIL empty_pulses: got %0d expected 0", got_n); end
    checks++; if (done_cyc !== 1) begin errors++; $display("FAIL empty_done: got %0d expected 1", done_cyc); end
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL empty_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_busy();
    int extra;
    run_txn(1'b0, 1'b0, 16'h0010, 8'h00, 1'b1);
    checks++; if (got_n !== 1) begin errors++; $display("FAIL busy_pulses: got %0d expected 1", got_n); end
    checks++; if (got_data[0] !== 16'hBEEF) begin errors++; $display("FAIL busy_data: got %h expected beef", got_data[0]); end
    checks++; if (done_cyc !== 3) begin errors++; $display("FAIL busy_done: got %0d expected 3", done_cyc); end
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid || done || !req_ready) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL busy_quiet: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_reset_mid_burst();
    logic [15:0] old_dat [4];
    int          extra;
    old_dat = '{16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03};
    for (int i = 0; i < 4; i++) wdata_tbl[i] = old_dat[i];
    run_txn(1'b1, 1'b1, 16'h0040, 8'h0F, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_multi = 1'b1;
    req_addr = 16'h0040; req_mask = 8'h0F; req_wdata = 16'h5500;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_reg !== 3'd0) begin errors++; $display("FAIL rb_word1: got valid=%b reg=%0d expected valid=1 reg=0", rsp_valid, rsp_reg); end
    @(negedge clk);
    checks++; if (rsp_reg !== 3'd1) begin errors++; $display("FAIL rb_word2_reg: got %0d expected 1", rsp_reg); end
    req_wdata = 16'h5501;
    proc_rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rb_ready: got %b expected 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rb_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rb_done: got %b expected 0", done); end
    checks++; if (rsp_reg !== 3'd0) begin errors++; $display("FAIL rb_rsp_reg: got %0d expected 0", rsp_reg); end
    checks++; if (rsp_data !== 16'd0) begin errors++; $display("FAIL rb_rsp_data: got %h expected 0000", rsp_data); end
    repeat (2) @(negedge clk);
    proc_rst = 1'b1;
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid || done) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL rb_quiet: got %0d active cycles expected 0", extra); end
    run_txn(1'b0, 1'b1, 16'h0040, 8'h0F, 1'b0);
    checks++; if (got_data[0] !== 16'h5500) begin errors++; $display("FAIL rb_mem[0x40]: got %h expected 5500", got_data[0]); end
    for (int i = 1; i < 4; i++) begin
      checks++; if (got_data[i] !== old_dat[i]) begin errors++; $display("FAIL rb_mem[%0d]: got %h expected %h", i, got_data[i], old_dat[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) wdata_tbl[i] = 16'd0;
    test_reset();
    test_single();
    test_multi_load();
    test_multi_store_wrap();
    test_empty_mask();
    test_busy();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
